sram_wb_arbiter: RTL

Two-master Wishbone arbiter that shares the single SRAM Wishbone slave port between two requesters, e.g. the management-core bus and the team's accelerator/DMA master.
- Round-robin grant; the grant is held for a master's whole cycle (cyc high).
- Request fields are muxed to the slave; ack and read data are routed back to the granted master only.
- A watchdog returns a Wishbone error if the slave fails to acknowledge.

---
 rtl/sram_wb_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/sram_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the single SRAM slave port,
// with a per-beat acknowledge watchdog that answers a stalled beat with err.
module sram_wb_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                m0_cyc_i,
  input  logic                m0_stb_i,
  input  logic                m0_we_i,
  input  logic [DATA_W/8-1:0] m0_sel_i,
  input  logic [ADDR_W-1:0]   m0_adr_i,
  input  logic [DATA_W-1:0]   m0_dat_i,
  output logic                m0_ack_o,
  output logic                m0_err_o,
  output logic [DATA_W-1:0]   m0_dat_o,
  input  logic                m1_cyc_i,
  input  logic                m1_stb_i,
  input  logic                m1_we_i,
  input  logic [DATA_W/8-1:0] m1_sel_i,
  input  logic [ADDR_W-1:0]   m1_adr_i,
  input  logic [DATA_W-1:0]   m1_dat_i,
  output logic                m1_ack_o,
  output logic                m1_err_o,
  output logic [DATA_W-1:0]   m1_dat_o,
  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [DATA_W/8-1:0] s_sel_o,
  output logic [ADDR_W-1:0]   s_adr_o,
  output logic [DATA_W-1:0]   s_dat_o,
  input  logic                s_ack_i,
  input  logic [DATA_W-1:0]   s_dat_i,
  output logic [1:0]          gnt_o
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t state, state_next;
  logic   last_grant;
  logic   grant0, grant1;
  logic   timeout;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state <= state_next;
      if (state == IDLE && state_next == GNT0)
        last_grant <= 1'b0;
      else if (state == IDLE && state_next == GNT1)
        last_grant <= 1'b1;
    end
  end

  // A grant always returns through IDLE, so two grants are separated by a dead cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i)
          state_next = last_grant ? GNT0 : GNT1;
        else if (m0_cyc_i)
          state_next = GNT0;
        else if (m1_cyc_i)
          state_next = GNT1;
      end
      GNT0:    if (!m0_cyc_i) state_next = IDLE;
      GNT1:    if (!m1_cyc_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign grant0 = (state == GNT0);
  assign grant1 = (state == GNT1);
  assign gnt_o  = {grant1, grant0};

  // Strobe is qualified by cyc so a master abandoning its cycle drops the slave beat at once.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    if (grant0) begin
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_cyc_i & m0_stb_i;
      s_we_o  = m0_we_i;
      s_sel_o = m0_sel_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
    end else if (grant1) begin
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_cyc_i & m1_stb_i;
      s_we_o  = m1_we_i;
      s_sel_o = m1_sel_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
    end
  end

  assign m0_ack_o = s_ack_i & grant0 & m0_cyc_i & m0_stb_i;
  assign m1_ack_o = s_ack_i & grant1 & m1_cyc_i & m1_stb_i;
  assign m0_err_o = timeout & grant0;
  assign m1_err_o = timeout & grant1;
  assign m0_dat_o = grant0 ? s_dat_i : '0;
  assign m1_dat_o = grant1 ? s_dat_i : '0;

  // err fires in the last waiting cycle only while ack is absent, so ack always wins a tie.
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_watchdog
      localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
      localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);
      logic [CNT_W-1:0] wait_cnt;

      assign timeout = s_stb_o & ~s_ack_i & (wait_cnt == LAST);

      always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
          wait_cnt <= '0;
        else if (!s_stb_o || s_ack_i || timeout)
          wait_cnt <= '0;
        else
          wait_cnt <= wait_cnt + 1'b1;
      end
    end else begin : g_no_watchdog
      assign timeout = 1'b0;
    end
  endgenerate

endmodule
